// File: rtl/mem_dma_master_pkg.sv
// Shared types and constants for the mem_dma_master word-copy DMA engine.
package mem_dma_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_FIN
  } state_e;

  localparam logic [3:0]  WSTRB_READ = 4'h0;
  localparam logic [3:0]  WSTRB_WORD = 4'hF;
  localparam logic [31:0] ADDR_STEP  = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/mem_dma_master_if.sv
// PicoRV32-native memory bus bundle; the DMA engine is the master, responders are slaves.
interface mem_dma_master_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_dma_master.sv
// Single-channel word-copy DMA master on the PicoRV32 native bus (read-then-write pairs).
// Optional per-transaction watchdog is compiled in with `define MEM_DMA_TIMEOUT_EN.
module mem_dma_master
  import mem_dma_master_pkg::*;
#(
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  mem_dma_master_if.master mem
);

  state_e           r_state,  w_state_nxt;
  logic [31:0]      r_src,    w_src_nxt;
  logic [31:0]      r_dst,    w_dst_nxt;
  logic [LEN_W-1:0] r_remain, w_remain_nxt;
  logic             r_valid,  w_valid_nxt;
  logic [31:0]      r_addr,   w_addr_nxt;
  logic [31:0]      r_wdata,  w_wdata_nxt;
  logic [3:0]       r_wstrb,  w_wstrb_nxt;
  logic             r_busy,   w_busy_nxt;
  logic             r_done,   w_done_nxt;
  logic             r_err,    w_err_nxt;
  logic             w_handshake;
  logic [31:0]      w_src_inc, w_dst_inc;

`ifdef MEM_DMA_TIMEOUT_EN
  logic [31:0]      r_tmo_cnt, w_tmo_cnt_nxt;
`else
  // Parameter kept referenced so both builds share one interface.
  if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
  end
`endif

  assign w_handshake = r_valid & mem.mem_ready;
  assign w_src_inc   = r_src + ADDR_STEP;
  assign w_dst_inc   = r_dst + ADDR_STEP;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_remain  <= '0;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef MEM_DMA_TIMEOUT_EN
      r_tmo_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_src     <= w_src_nxt;
      r_dst     <= w_dst_nxt;
      r_remain  <= w_remain_nxt;
      r_valid   <= w_valid_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wstrb   <= w_wstrb_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
`ifdef MEM_DMA_TIMEOUT_EN
      r_tmo_cnt <= w_tmo_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_src_nxt    = r_src;
    w_dst_nxt    = r_dst;
    w_remain_nxt = r_remain;
    w_valid_nxt  = r_valid;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_wstrb_nxt  = r_wstrb;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;
`ifdef MEM_DMA_TIMEOUT_EN
    w_tmo_cnt_nxt = '0;
`endif

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_src_nxt    = word_align(src_addr);
          w_dst_nxt    = word_align(dst_addr);
          w_remain_nxt = len;
          w_err_nxt    = 1'b0;
          if (len == '0) begin
            w_state_nxt = ST_FIN;
          end else begin
            w_valid_nxt = 1'b1;
            w_wstrb_nxt = WSTRB_READ;
            w_addr_nxt  = word_align(src_addr);
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (w_handshake) begin
          w_wdata_nxt = mem.mem_rdata;
          w_addr_nxt  = r_dst;
          w_wstrb_nxt = WSTRB_WORD;
          w_state_nxt = ST_WR;
        end
      end
      ST_WR: begin
        if (w_handshake) begin
          w_src_nxt    = w_src_inc;
          w_dst_nxt    = w_dst_inc;
          w_remain_nxt = r_remain - LEN_W'(1);
          if (r_remain == LEN_W'(1)) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_FIN;
          end else begin
            // Next read issued on the same edge: no idle cycle between words.
            w_addr_nxt  = w_src_inc;
            w_wstrb_nxt = WSTRB_READ;
            w_state_nxt = ST_RD;
          end
        end
      end
      ST_FIN: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

`ifdef MEM_DMA_TIMEOUT_EN
    // Counter only advances while a request is pending; any handshake or idle clears it.
    if ((r_state == ST_RD || r_state == ST_WR) && !mem.mem_ready) begin
      if (r_tmo_cnt == TIMEOUT_CYCLES - 1) begin
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b1;
        w_state_nxt = ST_FIN;
      end else begin
        w_tmo_cnt_nxt = r_tmo_cnt + 32'd1;
      end
    end
`endif
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign mem.mem_valid = r_valid;
  assign mem.mem_instr = 1'b0;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign mem.mem_wstrb = r_wstrb;

endmodule

// File: tb/tb_mem_dma_master.sv
// Self-checking bench for mem_dma_master: behavioural memory responder plus word-copy reference model.
module tb_mem_dma_master;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned TMO   = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, err;

  mem_dma_master_if mem_if ();

  mem_dma_master #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem      (mem_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] data;
  } txn_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];
  txn_t        log_q[$];
  txn_t        exp_q[$];
  int          wait_fixed = 1;   // <0: random 0..5 wait states per transaction
  bit          chk_hold = 1'b1;

  function automatic logic [31:0] bg(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return bg(a);
  endfunction

  // Reference: sequential word copy over a snapshot of memory, with the expected bus trace.
  function automatic void ref_copy(input logic [31:0] s, input logic [31:0] d, input int unsigned n);
    logic [31:0] a_r, a_w, v;
    ref_mem = mem_model;
    exp_q.delete();
    for (int unsigned i = 0; i < n; i++) begin
      a_r = {s[31:2], 2'b00} + 32'(i * 4);
      a_w = {d[31:2], 2'b00} + 32'(i * 4);
      v   = ref_mem.exists(a_r) ? ref_mem[a_r] : bg(a_r);
      ref_mem[a_w] = v;
      exp_q.push_back('{a_r, 4'h0, v});
      exp_q.push_back('{a_w, 4'hF, v});
    end
  endfunction

  // Responder: registered-ready slave with programmable wait states; checks request stability.
  initial begin : responder
    bit          req_open;
    int          wcnt, wtarget;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_wstrb;
    req_open = 1'b0; wcnt = 0; wtarget = 0;
    c_addr = '0; c_wdata = '0; c_wstrb = '0;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_if.mem_ready) req_open = 1'b0;
      mem_if.mem_ready = 1'b0;
      if (!mem_if.mem_valid) begin
        if (req_open && chk_hold) begin
          checks++;
          errors++;
          $display("FAIL valid_drop: mem_valid=0 before mem_ready, addr=%h", c_addr);
        end
        req_open = 1'b0;
      end else begin
        if (!req_open) begin
          req_open = 1'b1;
          c_addr = mem_if.mem_addr; c_wdata = mem_if.mem_wdata; c_wstrb = mem_if.mem_wstrb;
          wcnt = 0;
          wtarget = (wait_fixed < 0) ? int'($urandom_range(0, 5)) : wait_fixed;
        end else if (chk_hold) begin
          checks++;
          if ({mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wstrb} !== {c_addr, c_wdata, c_wstrb}) begin
            errors++;
            $display("FAIL hold_stable: got %h/%h/%h expected %h/%h/%h", mem_if.mem_addr,
                     mem_if.mem_wdata, mem_if.mem_wstrb, c_addr, c_wdata, c_wstrb);
          end
        end
        if (wcnt >= wtarget) begin
          mem_if.mem_ready = 1'b1;
          if (mem_if.mem_wstrb == 4'h0) begin
            mem_if.mem_rdata = mem_rd(mem_if.mem_addr);
            log_q.push_back('{mem_if.mem_addr, mem_if.mem_wstrb, mem_if.mem_rdata});
          end else begin
            mem_model[mem_if.mem_addr] = mem_if.mem_wdata;
            log_q.push_back('{mem_if.mem_addr, mem_if.mem_wstrb, mem_if.mem_wdata});
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  // Stimulus driver: call at a negedge; returns at a negedge three cycles after done.
  task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input int unsigned n,
                         input int unsigned restart_at, input int unsigned budget,
                         output int unsigned done_cyc, output int unsigned n_done,
                         output int unsigned valid_cnt, output bit busy_seen, output bit timed_out);
    int unsigned cyc;
    log_q.delete();
    done_cyc = 0; n_done = 0; valid_cnt = 0; busy_seen = 1'b0; timed_out = 1'b0; cyc = 0;
    start = 1'b1; src_addr = s; dst_addr = d; len = LEN_W'(n);
    forever begin
      @(negedge clk);
      cyc++;
      start = (restart_at != 0 && cyc == restart_at);
      if (start) begin
        src_addr = ~s; dst_addr = s; len = LEN_W'(n + 5);
      end
      if (mem_if.mem_valid) valid_cnt++;
      if (busy) busy_seen = 1'b1;
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (done_cyc != 0 && cyc >= done_cyc + 3) break;
      if (cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, mem_if.mem_valid, mem_if.mem_instr} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/err/valid/instr=%b expected 00000",
               {busy, done, err, mem_if.mem_valid, mem_if.mem_instr});
    end
    checks++;
    if ({mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wstrb} !== 68'h0) begin
      errors++;
      $display("FAIL reset_bus: addr=%h wdata=%h wstrb=%h expected zeros",
               mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wstrb);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_copy();
    int unsigned dc, nd, vc;
    bit bs, to, bad;
    for (int unsigned i = 0; i < 3; i++) mem_model[32'h1000 + 32'(i * 4)] = $urandom;
    wait_fixed = 1;
    ref_copy(32'h1000, 32'h2000, 3);
    do_copy(32'h1000, 32'h2000, 3, 0, 60, dc, nd, vc, bs, to);
    checks++;
    bad = (log_q.size() != exp_q.size());
    for (int i = 0; i < log_q.size() && !bad; i++) if (log_q[i] !== exp_q[i]) bad = 1'b1;
    if (bad || to) begin
      errors++;
      $display("FAIL basic_trace: got %0d txns (timeout=%0d) expected %0d txns R1000..W2008",
               log_q.size(), to, exp_q.size());
    end
    checks++;
    if (dc != 14) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d expected 14", dc);
    end
    checks++;
    if (nd != 1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: done pulses=%0d busy=%b err=%b expected 1/0/0", nd, busy, err);
    end
  endtask

  task automatic test_zero_len();
    int unsigned dc, nd, vc;
    bit bs, to;
    do_copy(32'h3000, 32'h4000, 0, 0, 20, dc, nd, vc, bs, to);
    checks++;
    if (dc != 2 || nd != 1) begin
      errors++;
      $display("FAIL zero_done: done at cycle %0d pulses %0d expected cycle 2 pulses 1", dc, nd);
    end
    checks++;
    if (vc != 0 || bs || log_q.size() != 0) begin
      errors++;
      $display("FAIL zero_bus: valid cycles=%0d busy_seen=%0d txns=%0d expected 0/0/0",
               vc, bs, log_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    int unsigned dc, nd, vc;
    bit bs, to, bad;
    wait_fixed = 1;
    ref_copy(32'h5000, 32'h6000, 4);
    do_copy(32'h5000, 32'h6000, 4, 5, 80, dc, nd, vc, bs, to);
    checks++;
    bad = (log_q.size() != exp_q.size());
    for (int i = 0; i < log_q.size() && !bad; i++) if (log_q[i] !== exp_q[i]) bad = 1'b1;
    if (bad || to) begin
      errors++;
      $display("FAIL busy_start_trace: got %0d txns expected %0d (original operands)",
               log_q.size(), exp_q.size());
    end
    checks++;
    if (dc != 18 || nd != 1) begin
      errors++;
      $display("FAIL busy_start_done: cycle %0d pulses %0d expected 18 / 1", dc, nd);
    end
  endtask

  task automatic test_random_waits();
    int unsigned dc, nd, vc, n;
    bit bs, to, bad;
    logic [31:0] s, d;
    wait_fixed = -1;
    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(1, 8);
      s = 32'h8000 + $urandom_range(0, 63);
      d = 32'h8000 + $urandom_range(0, 63);
      if (t == 0) begin
        s = 32'hFFFF_FFF9;
        d = 32'h0000_9003;
        n = 4;
      end
      ref_copy(s, d, n);
      do_copy(s, d, n, 0, n * 12 + 10, dc, nd, vc, bs, to);
      checks++;
      bad = (log_q.size() != exp_q.size());
      for (int i = 0; i < log_q.size() && !bad; i++) if (log_q[i] !== exp_q[i]) bad = 1'b1;
      if (bad || to) begin
        errors++;
        $display("FAIL rand_trace[%0d]: src=%h dst=%h len=%0d got %0d txns expected %0d",
                 t, s, d, n, log_q.size(), exp_q.size());
      end
      checks++;
      bad = 1'b0;
      for (int unsigned i = 0; i < n; i++) begin
        if (mem_rd({d[31:2], 2'b00} + 32'(i * 4)) !== ref_mem[{d[31:2], 2'b00} + 32'(i * 4)]) bad = 1'b1;
      end
      if (bad) begin
        errors++;
        $display("FAIL rand_mem[%0d]: destination contents differ from reference copy", t);
      end
      checks++;
      if (nd != 1 || busy !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL rand_status[%0d]: pulses=%0d busy=%b err=%b expected 1/0/0", t, nd, busy, err);
      end
    end
    wait_fixed = 1;
  endtask

  task automatic test_reset_mid();
    bit found, bad;
    found = 1'b0;
    wait_fixed = 2;
    start = 1'b1; src_addr = 32'hA000; dst_addr = 32'hB000; len = LEN_W'(4);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (mem_if.mem_valid && mem_if.mem_wstrb == 4'hF && mem_if.mem_addr == 32'hB004) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reach_wr2: write of word 2 to 0000b004 not observed, got addr %h", mem_if.mem_addr);
    end
    chk_hold = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_if.mem_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset: valid/busy/done=%b expected 000", {mem_if.mem_valid, busy, done});
    end
    reset = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (mem_if.mem_valid || busy || done) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mid_quiet: bus or status active after reset without a new start");
    end
    chk_hold = 1'b1;
    wait_fixed = 1;
  endtask

`ifdef MEM_DMA_TIMEOUT_EN
  task automatic test_timeout();
    int unsigned dc, nd, vc;
    bit bs, to, bad;
    chk_hold = 1'b0;
    wait_fixed = 1000;
    do_copy(32'hC000, 32'hD000, 2, 0, 60, dc, nd, vc, bs, to);
    checks++;
    if (vc != TMO || dc != TMO + 2 || nd != 1 || to) begin
      errors++;
      $display("FAIL tmo_timing: valid cycles=%0d done cycle=%0d pulses=%0d expected %0d/%0d/1",
               vc, dc, nd, TMO, TMO + 2);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || log_q.size() != 0) begin
      errors++;
      $display("FAIL tmo_err: err=%b busy=%b txns=%0d expected 1/0/0", err, busy, log_q.size());
    end
    chk_hold = 1'b1;
    wait_fixed = 1;
    ref_copy(32'hC000, 32'hD000, 1);
    do_copy(32'hC000, 32'hD000, 1, 0, 30, dc, nd, vc, bs, to);
    checks++;
    bad = (log_q.size() != exp_q.size());
    for (int i = 0; i < log_q.size() && !bad; i++) if (log_q[i] !== exp_q[i]) bad = 1'b1;
    if (err !== 1'b0 || bad || nd != 1) begin
      errors++;
      $display("FAIL tmo_clear: err=%b txns=%0d pulses=%0d expected err 0, 2 txns, 1 pulse",
               err, log_q.size(), nd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_len();
    test_start_while_busy();
    test_random_waits();
    test_reset_mid();
`ifdef MEM_DMA_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dma_master.md
Name: mem_dma_master

Overview:
- Single-channel word-copy DMA engine and initiator on the PicoRV32-native memory bus (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Drives the same bus that memory-mapped responders (GPIO, RAM) answer.
- Copies LEN 32-bit words from src_addr to dst_addr as read-then-write pairs.
- Sits beside the CPU behind the bus arbiter; started and monitored through simple control strobes.

Parameters:
- LEN_W, 16, width of the word-count input and internal remaining-count register.
- TIMEOUT_CYCLES, 1024, per-transaction watchdog limit; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; launches a copy when idle
- src_addr  in  32  source byte address; bits[1:0] ignored (forced 0)
- dst_addr  in  32  destination byte address; bits[1:0] ignored (forced 0)
- len  in  LEN_W  number of 32-bit words to copy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the copy completes or aborts
- err  out  1  sticky abort flag; cleared by the next accepted start
- mem_valid  out  1  bus request
- mem_instr  out  1  tied 0
- mem_ready  in  1  responder acknowledge
- mem_addr  out  32  request address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte strobes; 4'h0 = read, 4'hF = write
- mem_rdata  in  32  read data, valid when mem_ready=1

Behaviour:
- Reset values: mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, done=0, err=0; FSM in IDLE. Reset mid-transfer drops mem_valid at the next edge and discards the copy.
- All bus outputs are registered and held stable while mem_valid=1 and mem_ready=0.
- A transaction completes on the cycle mem_valid=1 && mem_ready=1.
- States:
  - IDLE: on start, latch src/dst (low bits zeroed) and len, clear err. If len==0, go to FIN. Otherwise set mem_valid=1, mem_wstrb=0, mem_addr=src, busy=1, and go to RD.
  - RD: wait for mem_ready. On ready, capture mem_rdata into mem_wdata, set mem_addr=dst, mem_wstrb=4'hF, keep mem_valid=1, go to WR.
  - WR: wait for mem_ready. On ready: src+=4, dst+=4, remaining-=1. If remaining becomes 0, mem_valid=0 and go to FIN. Otherwise issue the next read (addr=src, wstrb=0) in the same edge and go to RD.
  - FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- Back-to-back requests are allowed: no forced idle cycle between transactions. Responders that pulse ready for one cycle are compatible because the request changes on the ready edge.
- Latency per word: 2 bus transactions. Against a 1-wait-state responder, a word takes 4 cycles.
- Address arithmetic is modulo 2^32 and wraps silently. len is unsigned; the maximum is 2^LEN_W-1 words.
- start while busy: ignored, with no effect on the latched operands.
- mem_ready while mem_valid=0: ignored.
- len==0: done pulses 2 cycles after start, busy stays 0, no bus activity.

Optional Feature:
- Macro: MEM_DMA_TIMEOUT_EN.
- With the macro: a counter clears on each new request. If it reaches TIMEOUT_CYCLES in RD or WR without mem_ready, the engine sets mem_valid=0 and err=1, then goes to FIN. done still pulses, and remaining words are not copied.
- Without the macro: no counter; the engine waits indefinitely and err is constant 0.

Decomposition:
- Shared package: FSM state encoding (IDLE, RD, WR, FIN), WSTRB_READ=4'h0, WSTRB_WORD=4'hF, ADDR_STEP=4.
- No sub-module. The optional watchdog counter stays inline under the macro guard.

Test Plan:
- Reset release, then start with src=0x1000, dst=0x2000, len=3 against a 1-wait responder model: 6 transactions in order R1000, W2000, R1004, W2004, R1008, W2008; data copied exactly; one done pulse; busy low afterwards.
- start with len=0: done pulses 2 cycles later, mem_valid never asserted, busy stays 0.
- start asserted again during an active copy with different operands: ignored; the original copy completes unchanged.
- Responder inserting random 0-5 wait cycles: mem_addr/mem_wdata/mem_wstrb stable while waiting; mem_valid never drops before mem_ready.
- reset asserted during WR of word 2 of 4: next cycle mem_valid=0, busy=0, and no further bus activity without a new start.
- With MEM_DMA_TIMEOUT_EN and TIMEOUT_CYCLES=16, responder never readies: mem_valid drops 16 cycles after the request, err=1, done pulses; next start clears err.
